fi_campaign_ctrl: RTL and testbench



---
 rtl/fi_campaign_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fi_campaign_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fi_campaign_ctrl.sv
// fi_campaign_ctrl
// Sequencer for one single-fault injection run on the three-flop pipeline
// (q1 <= enable ? a : q1, q2 <= q1, q3 <= !q1).
// For each accepted start it:
//   - holds the pipeline in reset,
//   - drives LFSR stimulus,
//   - fires a one-cycle bit-flip strobe at the programmed flop,
//   - compares the pipeline against an internal golden copy.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             run request, accepted only in IDLE
//   cfg_target        0=q1, 1=q2, 2=q3, 3=golden run (no flip)
//   cfg_delay         stimulus cycles before the inject cycle
//   cfg_window        observe cycles after the inject cycle
//   busy, done        run in progress / one-cycle completion pulse
//   dut_reset         pipeline reset
//   dut_a, dut_enable pipeline stimulus
//   flip              one-hot flop inversion strobe
//   dut_o1..dut_o3    pipeline outputs
//   mismatch          sticky compare failure
//   first_err_cycle   cyc of the first mismatch
//   err_mask          accumulated differing bits {o3,o2,o1}
module fi_campaign_ctrl #(
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cfg_target,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_window,
    output logic             busy,
    output logic             done,
    output logic             dut_reset,
    output logic             dut_a,
    output logic             dut_enable,
    output logic [2:0]       flip,
    input  logic             dut_o1,
    input  logic             dut_o2,
    input  logic             dut_o3,
    output logic             mismatch,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [2:0]       err_mask
);

    typedef enum logic [2:0] {IDLE, RST, PRE, INJ, OBS, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [CNT_W-1:0] cyc_reg;
    logic [1:0]       target_reg;
    logic [CNT_W-1:0] delay_reg, window_reg;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic             accept;
    logic             active_now, active_next;
    logic [2:0]       flip_next;
    logic [2:0]       golden_reg;
    logic [2:0]       diff;

    assign active_now  = (state_reg == PRE) || (state_reg == INJ) || (state_reg == OBS);
    assign active_next = (state_next == PRE) || (state_next == INJ) || (state_next == OBS);
    assign diff        = {dut_o3, dut_o2, dut_o1} ^ golden_reg;

    // Next-state logic. rem_reg counts down the remaining cycles of the
    // current timed phase (RST, PRE or OBS).
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RST;
                    rem_next   = CNT_W'(1);
                    accept     = 1'b1;
                end
            end
            RST: begin
                if (rem_reg == '0) begin
                    state_next = (delay_reg == '0) ? INJ : PRE;
                    rem_next   = delay_reg - CNT_W'(1);
                end else begin
                    rem_next = rem_reg - CNT_W'(1);
                end
            end
            PRE: begin
                if (rem_reg == '0) state_next = INJ;
                else               rem_next   = rem_reg - CNT_W'(1);
            end
            INJ: begin
                state_next = (window_reg == '0) ? DONE : OBS;
                rem_next   = window_reg - CNT_W'(1);
            end
            OBS: begin
                if (rem_reg == '0) state_next = DONE;
                else               rem_next   = rem_reg - CNT_W'(1);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // lfsr_reg always holds the value whose bits drive the current cycle.
    // It is a right-shifting Fibonacci LFSR for x^16+x^14+x^13+x^11+1.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (accept)
            lfsr_next = LFSR_SEED;
        else if (active_now)
            lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    end

    // The flip strobe is one-hot on the latched target. Target 3 matches
    // no bit, so a golden run gets no strobe.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flip
            assign flip_next[gi] = (state_next == INJ) && (target_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            rem_reg         <= '0;
            cyc_reg         <= '0;
            target_reg      <= '0;
            delay_reg       <= '0;
            window_reg      <= '0;
            lfsr_reg        <= LFSR_SEED;
            busy            <= 1'b0;
            done            <= 1'b0;
            dut_reset       <= 1'b1;
            dut_a           <= 1'b0;
            dut_enable      <= 1'b0;
            flip            <= '0;
            golden_reg      <= '0;
            mismatch        <= 1'b0;
            first_err_cycle <= '0;
            err_mask        <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            lfsr_reg  <= lfsr_next;

            if (accept) begin
                target_reg <= cfg_target;
                delay_reg  <= cfg_delay;
                window_reg <= cfg_window;
            end

            // cyc restarts at 0 on the first PRE/INJ cycle after RST.
            if (state_reg == RST && state_next != RST)
                cyc_reg <= '0;
            else if (active_now)
                cyc_reg <= cyc_reg + CNT_W'(1);

            // Outputs are registered from the next-state decode, so each
            // one is aligned with the state it belongs to.
            busy       <= (state_next == RST) || active_next;
            done       <= (state_next == DONE);
            dut_reset  <= (state_next == RST);
            dut_a      <= active_next & lfsr_next[0];
            dut_enable <= active_next & lfsr_next[1];
            flip       <= flip_next;

            // The golden copy sees exactly the registered stimulus the
            // pipeline sees, on the same edge, but it is never flipped.
            if (accept || dut_reset) begin
                golden_reg <= '0;
            end else begin
                golden_reg[0] <= dut_enable ? dut_a : golden_reg[0];
                golden_reg[1] <= golden_reg[0];
                golden_reg[2] <= ~golden_reg[0];
            end

            if (accept) begin
                mismatch        <= 1'b0;
                err_mask        <= '0;
                first_err_cycle <= '0;
            end else if (active_now && diff != 3'b000) begin
                err_mask <= err_mask | diff;
                mismatch <= 1'b1;
                if (!mismatch)
                    first_err_cycle <= cyc_reg;
            end
        end
    end

endmodule

// File: tb/tb_fi_campaign_ctrl.sv
module tb_fi_campaign_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_target;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_window;
    logic        busy, done, dut_reset, dut_a, dut_enable;
    logic [2:0]  flip;
    logic        dut_o1, dut_o2, dut_o3;
    logic        mismatch;
    logic [15:0] first_err_cycle;
    logic [2:0]  err_mask;

    int checks = 0;
    int errors = 0;

    // Values collected by run(), indexed by cycle number c (start is sampled in c0).
    int         done_cyc, n_done, n_flip, flip_cyc;
    logic [2:0] flip_val;
    logic       busy_tr [0:63];
    logic       drst_tr [0:63];
    logic [1:0] stim_tr [0:63];
    logic [1:0] saved_tr [0:63];

    // Faithful three-flop pipeline under test.
    logic q1, q2, q3;
    always @(posedge clk) begin
        if (dut_reset) begin
            q1 <= 1'b0; q2 <= 1'b0; q3 <= 1'b0;
        end else begin
            q1 <= (dut_enable ? dut_a : q1) ^ flip[0];
            q2 <= q1 ^ flip[1];
            q3 <= ~q1 ^ flip[2];
        end
    end
    assign dut_o1 = q1;
    assign dut_o2 = q2;
    assign dut_o3 = q3;

    fi_campaign_ctrl #(.CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_target(cfg_target), .cfg_delay(cfg_delay), .cfg_window(cfg_window),
        .busy(busy), .done(done), .dut_reset(dut_reset),
        .dut_a(dut_a), .dut_enable(dut_enable), .flip(flip),
        .dut_o1(dut_o1), .dut_o2(dut_o2), .dut_o3(dut_o3),
        .mismatch(mismatch), .first_err_cycle(first_err_cycle), .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    // Launch one run and observe it until a few cycles past done.
    // With hold=1, start stays high until done and the config changes in c2.
    task automatic run(input logic [1:0] t, input logic [15:0] d, input logic [15:0] w, input bit hold);
        @(negedge clk);
        cfg_target = t; cfg_delay = d; cfg_window = w; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        done_cyc = -1; n_done = 0; n_flip = 0; flip_cyc = -1; flip_val = 3'b000;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (hold && c == 2) begin
                cfg_target = 2'd0; cfg_delay = 16'd0; cfg_window = 16'd0;
            end
            if (c < 64) begin
                busy_tr[c] = busy; drst_tr[c] = dut_reset; stim_tr[c] = {dut_enable, dut_a};
            end
            if (flip !== 3'b000) begin
                n_flip++; flip_cyc = c; flip_val = flip;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = c; start = 1'b0; end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout: done never seen (target=%0d D=%0d W=%0d)", t, d, w);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; cfg_target = 2'd0; cfg_delay = 16'd0; cfg_window = 16'd0;
        #1;
        checks++;
        if ({busy, done, dut_reset, dut_a, dut_enable, flip, mismatch, err_mask} !== 12'b001_00_000_0_000) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b dut_reset=%b a=%b en=%b flip=%b mm=%b mask=%b, need 0 0 1 0 0 000 0 000",
                     busy, done, dut_reset, dut_a, dut_enable, flip, mismatch, err_mask);
        end
        checks++;
        if (first_err_cycle !== 16'd0) begin
            errors++; $display("FAIL reset_first_err: got %0d need 0", first_err_cycle);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_reset !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_outputs: got dut_reset=%b busy=%b need 0 0", dut_reset, busy);
        end
        $display("test_reset: reset and idle outputs checked");
    endtask

    task automatic test_golden;
        run(2'd3, 16'd5, 16'd20, 1'b0);
        checks++;
        if (done_cyc != 29 || n_done != 1) begin
            errors++; $display("FAIL golden_done: got cycle %0d count %0d need cycle 29 count 1", done_cyc, n_done);
        end
        checks++;
        if (drst_tr[1] !== 1'b1 || drst_tr[2] !== 1'b1 || drst_tr[3] !== 1'b0) begin
            errors++; $display("FAIL golden_dut_reset: got c1..c3=%b%b%b need 110", drst_tr[1], drst_tr[2], drst_tr[3]);
        end
        checks++;
        if (busy_tr[1] !== 1'b1 || busy_tr[28] !== 1'b1 || busy_tr[29] !== 1'b0) begin
            errors++; $display("FAIL golden_busy: got c1=%b c28=%b c29=%b need 1 1 0", busy_tr[1], busy_tr[28], busy_tr[29]);
        end
        checks++;
        if (mismatch !== 1'b0 || err_mask !== 3'b000 || n_flip != 0) begin
            errors++; $display("FAIL golden_result: got mm=%b mask=%b flips=%0d need 0 000 0", mismatch, err_mask, n_flip);
        end
        // Seed 16'hACE1 puts a=1, enable=0 on the first PRE cycle.
        checks++;
        if (stim_tr[3] !== 2'b01) begin
            errors++; $display("FAIL golden_first_stim: got {en,a}=%b need 01", stim_tr[3]);
        end
        $display("test_golden: done at c%0d mismatch=%b err_mask=%b", done_cyc, mismatch, err_mask);
    endtask

    task automatic test_target_q2;
        run(2'd1, 16'd4, 16'd8, 1'b0);
        checks++;
        if (n_flip != 1 || flip_cyc != 7 || flip_val !== 3'b010) begin
            errors++; $display("FAIL q2_flip: got %0d strobes, last c%0d value %b, need 1 at c7 value 010", n_flip, flip_cyc, flip_val);
        end
        checks++;
        if (done_cyc != 16) begin
            errors++; $display("FAIL q2_done: got c%0d need c16", done_cyc);
        end
        checks++;
        if (mismatch !== 1'b1 || err_mask !== 3'b010 || first_err_cycle !== 16'd5) begin
            errors++; $display("FAIL q2_result: got mm=%b mask=%b first=%0d need 1 010 5", mismatch, err_mask, first_err_cycle);
        end
        $display("test_target_q2: mismatch=%b err_mask=%b first_err_cycle=%0d", mismatch, err_mask, first_err_cycle);
    endtask

    task automatic test_target_q1;
        run(2'd0, 16'd10, 16'd16, 1'b0);
        checks++;
        if (flip_cyc != 13 || flip_val !== 3'b001) begin
            errors++; $display("FAIL q1_flip: got c%0d value %b need c13 value 001", flip_cyc, flip_val);
        end
        checks++;
        if (done_cyc != 30) begin
            errors++; $display("FAIL q1_done: got c%0d need c30", done_cyc);
        end
        // q1 differs from cyc 11; q2 and q3 sample it one edge later.
        checks++;
        if (mismatch !== 1'b1 || err_mask !== 3'b111 || first_err_cycle !== 16'd11) begin
            errors++; $display("FAIL q1_result: got mm=%b mask=%b first=%0d need 1 111 11", mismatch, err_mask, first_err_cycle);
        end
        $display("test_target_q1: mismatch=%b err_mask=%b first_err_cycle=%0d", mismatch, err_mask, first_err_cycle);
    endtask

    task automatic test_zero_delay_window;
        run(2'd2, 16'd0, 16'd0, 1'b0);
        checks++;
        if (n_flip != 1 || flip_cyc != 3 || flip_val !== 3'b100) begin
            errors++; $display("FAIL zero_flip: got %0d strobes at c%0d value %b need 1 at c3 value 100", n_flip, flip_cyc, flip_val);
        end
        checks++;
        if (done_cyc != 4 || drst_tr[3] !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done c%0d dut_reset@c3=%b need c4 0", done_cyc, drst_tr[3]);
        end
        checks++;
        if (mismatch !== 1'b0 || err_mask !== 3'b000) begin
            errors++; $display("FAIL zero_result: got mm=%b mask=%b need 0 000", mismatch, err_mask);
        end
        $display("test_zero_delay_window: done at c%0d mismatch=%b", done_cyc, mismatch);
    endtask

    task automatic test_back_to_back;
        run(2'd1, 16'd4, 16'd8, 1'b1);
        checks++;
        if (n_done != 1 || done_cyc != 16) begin
            errors++; $display("FAIL held_start_done: got %0d pulses first at c%0d need 1 at c16", n_done, done_cyc);
        end
        checks++;
        if (n_flip != 1 || flip_cyc != 7 || flip_val !== 3'b010) begin
            errors++; $display("FAIL held_start_flip: got %0d strobes c%0d value %b need 1 c7 010", n_flip, flip_cyc, flip_val);
        end
        checks++;
        if (err_mask !== 3'b010 || first_err_cycle !== 16'd5 || busy !== 1'b0) begin
            errors++; $display("FAIL held_start_result: got mask=%b first=%0d busy=%b need 010 5 0", err_mask, first_err_cycle, busy);
        end
        $display("test_back_to_back: done pulses=%0d err_mask=%b", n_done, err_mask);
    endtask

    task automatic test_reset_mid_run;
        int saw_done;
        @(negedge clk);
        cfg_target = 2'd0; cfg_delay = 16'd3; cfg_window = 16'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            saved_tr[c] = {dut_enable, dut_a};
        end
        checks++;
        if (mismatch !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midrun_pre: got mm=%b busy=%b need 1 1", mismatch, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || dut_reset !== 1'b1 || flip !== 3'b000 || mismatch !== 1'b0 ||
            err_mask !== 3'b000 || first_err_cycle !== 16'd0 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: got busy=%b drst=%b flip=%b mm=%b mask=%b first=%0d done=%b need 0 1 000 0 000 0 0",
                               busy, dut_reset, flip, mismatch, err_mask, first_err_cycle, done);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done != 0) begin
            errors++; $display("FAIL midrun_no_done: got done/busy activity after reset, need none");
        end
        run(2'd0, 16'd3, 16'd20, 1'b0);
        checks++;
        if (done_cyc != 27 || mismatch !== 1'b1 || first_err_cycle !== 16'd4) begin
            errors++; $display("FAIL rerun_result: got done c%0d mm=%b first=%0d need c27 1 4", done_cyc, mismatch, first_err_cycle);
        end
        for (int c = 3; c <= 9; c++) begin
            checks++;
            if (stim_tr[c] !== saved_tr[c]) begin
                errors++; $display("FAIL rerun_stim_c%0d: got {en,a}=%b need %b", c, stim_tr[c], saved_tr[c]);
            end
        end
        $display("test_reset_mid_run: rerun done at c%0d, stimulus c3..c9 compared", done_cyc);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_target_q2();
        test_target_q1();
        test_zero_delay_window();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
